// File: rtl/sram_pkg.sv
// Shared types and default timing for the async SRAM controller.
package sram_pkg;

  localparam int unsigned SRAM_DATA_WIDTH      = 32;
  localparam int unsigned SRAM_ADDR_WIDTH      = 20;
  localparam int unsigned SRAM_RD_WAIT_CYCLES  = 2;
  localparam int unsigned SRAM_WR_PULSE_CYCLES = 1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } sram_state_t;

  typedef struct packed {
    logic                       we;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [SRAM_DATA_WIDTH-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_io_pad.sv
// Tristate driver for the SRAM data pins, kept separate for pad mapping.
module sram_io_pad
  import sram_pkg::*;
(
  input  logic [SRAM_DATA_WIDTH-1:0] dout,
  input  logic                       oe_drive,
  inout  wire  [SRAM_DATA_WIDTH-1:0] ram_data,
  output logic [SRAM_DATA_WIDTH-1:0] din
);

  assign ram_data = oe_drive ? dout : 'z;
  assign din      = ram_data;

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready to async SRAM strobe sequencer, one instance per chip.
// Define SRAM_CTRL_WBUF_EN for a single-entry posted-write buffer.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = SRAM_ADDR_WIDTH,
  parameter int unsigned RD_WAIT_CYCLES  = SRAM_RD_WAIT_CYCLES,
  parameter int unsigned WR_PULSE_CYCLES = SRAM_WR_PULSE_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] req_wdata,
  output logic                       resp_valid,
  output logic [SRAM_DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0]      ram_addr,
  inout  wire  [SRAM_DATA_WIDTH-1:0] ram_data,
  output logic                       ram_ce_n,
  output logic                       ram_oe_n,
  output logic                       ram_we_n
);

  localparam int unsigned MAX_WAIT = (RD_WAIT_CYCLES > WR_PULSE_CYCLES) ? RD_WAIT_CYCLES
                                                                          : WR_PULSE_CYCLES;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT) + 1;

  sram_state_t                state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [SRAM_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d, din;
  logic                       ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic                       drive_q, drive_d, resp_valid_q, resp_valid_d;
  logic                       start_c, rd_done_c, wr_done_c;
  sram_req_t                  req_c, start_req_c;

  assign req_c = '{we: req_we, addr: SRAM_ADDR_WIDTH'(req_addr), wdata: req_wdata};

  // Strobe FSM; pin registers are loaded from the next state so pins never see req_* directly
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_done_c = 1'b0;
    wr_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          addr_d  = ADDR_WIDTH'(start_req_c.addr);
          wdata_d = start_req_c.wdata;
          if (start_req_c.we) begin
            state_d = WR_SETUP;
          end else begin
            state_d = RD;
            cnt_d   = CNT_W'(RD_WAIT_CYCLES - 1);
          end
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          rd_done_c = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = CNT_W'(WR_PULSE_CYCLES - 1);
      end
      WR_PULSE: begin
        if (cnt_q == '0) state_d = WR_HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      WR_HOLD: begin
        wr_done_c = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ce_n_d  = (state_d == IDLE);
    oe_n_d  = (state_d != RD);
    we_n_d  = (state_d != WR_PULSE);
    drive_d = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
  end

`ifdef SRAM_CTRL_WBUF_EN
  logic      wbuf_vld_q, wbuf_vld_d, rd_pend_q, rd_pend_d, accept_c, hit_c;
  sram_req_t wbuf_q, wbuf_d, rd_q, rd_d;

  // Only writes are blocked by a full buffer, so readiness depends on req_we
  assign hit_c       = wbuf_vld_q && (wbuf_q.addr == req_c.addr);
  assign req_ready   = !rd_pend_q && !(req_we && wbuf_vld_q);
  assign accept_c    = req_valid && req_ready;
  assign start_c     = wbuf_vld_q || rd_pend_q;
  assign start_req_c = wbuf_vld_q ? wbuf_q : rd_q;

  // Buffer drain has priority over a pending read miss
  always_comb begin
    wbuf_vld_d   = wbuf_vld_q;
    wbuf_d       = wbuf_q;
    rd_pend_d    = rd_pend_q;
    rd_d         = rd_q;
    resp_valid_d = rd_done_c;
    rdata_d      = rd_done_c ? din : rdata_q;
    if (wr_done_c) wbuf_vld_d = 1'b0;
    if (rd_done_c) rd_pend_d  = 1'b0;
    if (accept_c) begin
      if (req_we) begin
        wbuf_vld_d   = 1'b1;
        wbuf_d       = req_c;
        resp_valid_d = 1'b1;
      end else if (hit_c) begin
        resp_valid_d = 1'b1;
        rdata_d      = wbuf_q.wdata;
      end else begin
        rd_pend_d = 1'b1;
        rd_d      = req_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbuf_vld_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      wbuf_q     <= '0;
      rd_q       <= '0;
    end else begin
      wbuf_vld_q <= wbuf_vld_d;
      rd_pend_q  <= rd_pend_d;
      wbuf_q     <= wbuf_d;
      rd_q       <= rd_d;
    end
  end
`else
  logic ready_q, ready_d;

  assign req_ready   = ready_q;
  assign start_c     = req_valid && ready_q;
  assign start_req_c = req_c;

  always_comb begin
    ready_d      = (state_d == IDLE);
    resp_valid_d = rd_done_c || wr_done_c;
    rdata_d      = rd_done_c ? din : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ready_q <= 1'b1;
    else     ready_q <= ready_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      drive_q      <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      drive_q      <= drive_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign ram_addr   = addr_q;
  assign ram_ce_n   = ce_n_q;
  assign ram_oe_n   = oe_n_q;
  assign ram_we_n   = we_n_q;

  sram_io_pad u_pad (
    .dout     (wdata_q),
    .oe_drive (drive_q),
    .ram_data (ram_data),
    .din      (din)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: pin-level SRAM model plus a request-level reference memory.
module tb_sram_ctrl;

  localparam int unsigned AW = 20;
`ifdef SRAM_CTRL_WBUF_EN
  localparam int WR_LAT = 1;
  localparam int RD_LAT = -1;
`else
  localparam int WR_LAT = 4;
  localparam int RD_LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] ram_addr;
  wire  [31:0]   ram_data;
  logic          ram_ce_n, ram_oe_n, ram_we_n;

  int checks = 0;
  int failures = 0;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [31:0]   ref_mem [int unsigned];
  logic          model_en = 1'b0;
  logic [AW-1:0] last_waddr = '0, last_raddr = '0;
  logic [31:0]   last_wdata = '0;
  int            oe_low = 0, we_low = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.ADDR_WIDTH(AW), .RD_WAIT_CYCLES(2), .WR_PULSE_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  // Async SRAM: drives data while selected for read, latches on the rising edge of we_n
  assign ram_data = (!ram_ce_n && !ram_oe_n && ram_we_n) ? mem[ram_addr] : 'z;
  always @(posedge ram_we_n) if (model_en && !ram_ce_n) mem[ram_addr] = ram_data;

  initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
    return ref_mem.exists(32'(a)) ? ref_mem[32'(a)] : 32'h0;
  endfunction

  // Pin-level protocol checks every cycle outside reset
  always @(negedge clk) begin
    if (!rst && model_en) begin
      chk("oe_we_overlap", 64'({ram_oe_n, ram_we_n} != 2'b00), 64'(1));
      if (!ram_oe_n) oe_low++;
      if (!ram_we_n) we_low++;
      if (dut.u_pad.oe_drive) begin
        chk("drive_while_oe", 64'(ram_oe_n), 64'(1));
        chk("wr_addr", 64'(ram_addr), 64'(last_waddr));
        chk("wr_data", 64'(ram_data), 64'(last_wdata));
      end
      if (!ram_oe_n) chk("rd_addr", 64'(ram_addr), 64'(last_raddr));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 of the response cycle
  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    int n = 0;
    oe_low = 0;
    we_low = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    #1;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("ready_wait", 64'(n < 50), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
    if (we) begin
      last_waddr = a; last_wdata = d; ref_mem[32'(a)] = d;
    end else begin
      last_raddr = a;
    end
    lat = 1;
    while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("resp_timeout", 64'(resp_valid), 64'(1));
    rd = resp_rdata;
  endtask

  task automatic wr(input string tag, input logic [AW-1:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int lat;
    do_req(1'b1, a, d, rd, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(WR_LAT));
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input int lat_exp);
    logic [31:0] rd;
    int lat;
    do_req(1'b0, a, 32'h0, rd, lat);
    chk({tag, "_data"}, 64'(rd), 64'(exp_rd(a)));
    if (lat_exp >= 0) chk({tag, "_lat"}, 64'(lat), 64'(lat_exp));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] pool [6];
    int n;

    // 1: reset then idle
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_strobes", 64'({ram_ce_n, ram_oe_n, ram_we_n}), 64'(3'b111));
      chk("idle_drive", 64'(dut.u_pad.oe_drive), 64'(0));
      chk("idle_ready", 64'(req_ready), 64'(1));
      chk("idle_resp", 64'(resp_valid), 64'(0));
      chk("idle_rdata", 64'(resp_rdata), 64'(0));
    end
    @(posedge clk); #1;

    // 2: single write
    wr("wr10", 20'h00010, 32'hDEADBEEF);
    idle(8);
    chk("wr10_we_pulse", 64'(we_low), 64'(1));
    chk("wr10_mem", 64'(mem[20'h00010]), 64'(32'hDEADBEEF));

    // 3: read it back
    rd_chk("rd10", 20'h00010, RD_LAT);
    chk("rd10_oe_cycles", 64'(oe_low), 64'(2));

    // 4: back-to-back write then read at top address
    wr("wrfff", 20'hFFFFF, 32'h12345678);
    rd_chk("rdfff", 20'hFFFFF, RD_LAT);
    idle(8);
    chk("wrfff_mem", 64'(mem[20'hFFFFF]), 64'(32'h12345678));

    // 5: reset during the write pulse
    req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h00030; req_wdata = 32'hCAFEF00D;
    #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    last_waddr = 20'h00030;
    last_wdata = 32'hCAFEF00D;
    n = 0;
    while (ram_we_n && n < 20) begin @(posedge clk); #1; n++; end
    chk("rst_reach_pulse", 64'(ram_we_n), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_strobes", 64'({ram_ce_n, ram_oe_n, ram_we_n}), 64'(3'b111));
    chk("rst_drive", 64'(dut.u_pad.oe_drive), 64'(0));
    chk("rst_resp", 64'(resp_valid), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(1));
    chk("rst_addr", 64'(ram_addr), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_resp", 64'(resp_valid), 64'(0));
    end
    @(posedge clk); #1;
    rd_chk("rst_rd0", 20'h00000, RD_LAT);

`ifdef SRAM_CTRL_WBUF_EN
    // 6: posted write then hitting read
    wr("wb20", 20'h00020, 32'hA5A5A5A5);
    rd_chk("wb20_hit", 20'h00020, 1);
    idle(8);
    chk("wb20_mem", 64'(mem[20'h00020]), 64'(32'hA5A5A5A5));
`endif

    // Randomized traffic over a small address pool
    pool[0] = 20'h00000;
    pool[1] = 20'hFFFFF;
    for (int i = 2; i < 6; i++) begin
      pool[i] = AW'($urandom);
      if (pool[i] == 20'h00030) pool[i] = 20'h00031;
    end
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      a = pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 1) wr("rnd_wr", a, $urandom);
      else                           rd_chk("rnd_rd", a, RD_LAT);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end
    idle(10);
    for (int i = 0; i < 6; i++) chk("final_mem", 64'(mem[pool[i]]), 64'(exp_rd(pool[i])));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
